arduino_cmd_tx: RTL and testbench

- Encodes the drive-direction flags and operating mode into a single command byte.
- Serialises that byte back to the Arduino over an 8N1 UART link (8E1 when parity is compiled in).
- Is the FPGA-to-Arduino counterpart of the inbound `arduino_command` path and sits beside `mode_select` and `manual_mode`.
- Transmits on every command change, and re-sends the last command on a heartbeat interval so the Arduino can detect a lost link.

---
 rtl/arduino_cmd_tx.sv | 200 ++++++++++++++++++++
 tb/tb_arduino_cmd_tx.sv | 265 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/arduino_cmd_tx.sv
// Encodes drive flags plus mode into a command byte and sends it to the Arduino over a UART link,
// on every change and on a heartbeat interval. Build macro CMD_PARITY_EN adds an even parity bit (8E1).
module arduino_cmd_tx #(
  parameter int CLK_FREQ     = 50_000_000,
  parameter int BAUD         = 115200,
  parameter int HEARTBEAT_MS = 100
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       auto_on,
  input  logic       w,
  input  logic       s,
  input  logic       a,
  input  logic       d,
  input  logic       wa,
  input  logic       wd,
  input  logic       as,
  input  logic       ds,
  input  logic       stop,
  output logic       tx,
  output logic       busy,
  output logic [7:0] sent_byte,
  output logic       frame_done
);

  localparam int CLKS_PER_BIT = CLK_FREQ / BAUD;
  localparam int HB_CLKS      = (CLK_FREQ / 1000) * HEARTBEAT_MS;
  localparam int BAUD_W       = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam int HB_W         = (HB_CLKS > 1) ? $clog2(HB_CLKS) : 1;
  localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 1);
  localparam logic [HB_W-1:0]   HB_LAST   = HB_W'(HB_CLKS - 1);

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
    ST_STOP   = 3'd3
`ifdef CMD_PARITY_EN
    , ST_PARITY = 3'd4
`endif
  } state_e;

`ifdef CMD_PARITY_EN
  function automatic logic even_parity(input logic [7:0] b);
    return ^b;
  endfunction
`endif

  state_e            state_q, state_d;
  logic [7:0]        cmd_q, cmd_d;
  logic [7:0]        sent_q, sent_d;
  logic [7:0]        shift_q, shift_d;
  logic [BAUD_W-1:0] baud_q, baud_d;
  logic [2:0]        bit_q, bit_d;
  logic [HB_W-1:0]   hb_q, hb_d;
  logic              force_q, force_d;
  logic              tx_q, tx_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic [3:0]        dir_code;
  logic              start_req;

  // Direction priority encoder: stop beats the diagonals, diagonals beat the single directions.
  always_comb begin
    dir_code = 4'h0;
    if (stop)    dir_code = 4'h0;
    else if (wa) dir_code = 4'h5;
    else if (wd) dir_code = 4'h6;
    else if (as) dir_code = 4'h7;
    else if (ds) dir_code = 4'h8;
    else if (w)  dir_code = 4'h1;
    else if (s)  dir_code = 4'h2;
    else if (a)  dir_code = 4'h3;
    else if (d)  dir_code = 4'h4;
    else         dir_code = 4'h0;
    cmd_d = {auto_on, 3'b000, dir_code};
  end

  // Frame sequencer, heartbeat counter and registered line outputs derived from the next state.
  always_comb begin
    state_d   = state_q;
    sent_d    = sent_q;
    shift_d   = shift_q;
    baud_d    = baud_q;
    bit_d     = bit_q;
    hb_d      = hb_q;
    force_d   = force_q;
    start_req = (cmd_q != sent_q) || force_q || (hb_q == HB_LAST);

    case (state_q)
      ST_IDLE: begin
        if (start_req) begin
          sent_d  = cmd_q;
          shift_d = cmd_q;
          force_d = 1'b0;
          hb_d    = {HB_W{1'b0}};
          baud_d  = {BAUD_W{1'b0}};
          state_d = ST_START;
        end else if (hb_q != HB_LAST) begin
          hb_d = hb_q + HB_W'(1);
        end else begin
          hb_d = hb_q;
        end
      end
      ST_START: begin
        if (baud_q == BAUD_LAST) begin
          baud_d  = {BAUD_W{1'b0}};
          bit_d   = 3'd0;
          state_d = ST_DATA;
        end else begin
          baud_d = baud_q + BAUD_W'(1);
        end
      end
      ST_DATA: begin
        if (baud_q == BAUD_LAST) begin
          baud_d = {BAUD_W{1'b0}};
          if (bit_q == 3'd7) begin
`ifdef CMD_PARITY_EN
            state_d = ST_PARITY;
`else
            state_d = ST_STOP;
`endif
          end else begin
            bit_d   = bit_q + 3'd1;
            shift_d = {1'b0, shift_q[7:1]};
          end
        end else begin
          baud_d = baud_q + BAUD_W'(1);
        end
      end
`ifdef CMD_PARITY_EN
      ST_PARITY: begin
        if (baud_q == BAUD_LAST) begin
          baud_d  = {BAUD_W{1'b0}};
          state_d = ST_STOP;
        end else begin
          baud_d = baud_q + BAUD_W'(1);
        end
      end
`endif
      ST_STOP: begin
        if (baud_q == BAUD_LAST) begin
          baud_d  = {BAUD_W{1'b0}};
          state_d = ST_IDLE;
        end else begin
          baud_d = baud_q + BAUD_W'(1);
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    case (state_d)
      ST_START:  tx_d = 1'b0;
      ST_DATA:   tx_d = shift_d[0];
`ifdef CMD_PARITY_EN
      ST_PARITY: tx_d = even_parity(sent_d);
`endif
      default:   tx_d = 1'b1;
    endcase
    busy_d = (state_d != ST_IDLE);
    done_d = (state_d == ST_STOP) && (baud_d == BAUD_LAST);
  end

  // State and output registers; reset leaves force set so one frame always follows reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      cmd_q   <= 8'h00;
      sent_q  <= 8'h00;
      shift_q <= 8'h00;
      baud_q  <= {BAUD_W{1'b0}};
      bit_q   <= 3'd0;
      hb_q    <= {HB_W{1'b0}};
      force_q <= 1'b1;
      tx_q    <= 1'b1;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cmd_q   <= cmd_d;
      sent_q  <= sent_d;
      shift_q <= shift_d;
      baud_q  <= baud_d;
      bit_q   <= bit_d;
      hb_q    <= hb_d;
      force_q <= force_d;
      tx_q    <= tx_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign tx         = tx_q;
  assign busy       = busy_q;
  assign sent_byte  = sent_q;
  assign frame_done = done_q;

endmodule

// File: tb/tb_arduino_cmd_tx.sv
// Bench for arduino_cmd_tx: frame-level reference model compared every cycle, plus a UART
// receiver and directed scenarios with hand-computed expectations, then randomized flag traffic.
module tb_arduino_cmd_tx;

  localparam int CPB = 10;
  localparam int HB  = 50;
`ifdef CMD_PARITY_EN
  localparam int NBITS = 11;
`else
  localparam int NBITS = 10;
`endif
  localparam int FRAME_CLKS = NBITS * CPB;

  logic clk = 1'b0;
  logic rst, auto_on, w, s, a, d, wa, wd, as, ds, stop;
  logic tx, busy, frame_done;
  logic [7:0] sent_byte;

  arduino_cmd_tx #(.CLK_FREQ(1000), .BAUD(100), .HEARTBEAT_MS(50)) dut (
    .clk(clk), .rst(rst), .auto_on(auto_on),
    .w(w), .s(s), .a(a), .d(d), .wa(wa), .wd(wd), .as(as), .ds(ds), .stop(stop),
    .tx(tx), .busy(busy), .sent_byte(sent_byte), .frame_done(frame_done)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // Reference model: what the line must carry, tracked per frame position.
  logic [7:0] m_cmd, m_sent;
  bit m_force, m_busy, m_in_rst;
  int m_hb, m_pos;
  int m_bits [NBITS];

  function automatic logic [7:0] model_encode();
    logic pri [9];
    int codes [9];
    int code;
    pri   = '{stop, wa, wd, as, ds, w, s, a, d};
    codes = '{0, 5, 6, 7, 8, 1, 2, 3, 4};
    code  = 0;
    for (int i = 8; i >= 0; i--) if (pri[i] === 1'b1) code = codes[i];
    return {auto_on, 3'b000, 4'(code)};
  endfunction

  task automatic model_step();
    logic [7:0] nxt;
    nxt = model_encode();
    m_in_rst = (rst === 1'b1);
    if (m_in_rst) begin
      m_cmd = 8'h00; m_sent = 8'h00; m_force = 1'b1; m_hb = 0; m_busy = 1'b0; m_pos = 0;
    end else begin
      if (m_busy) begin
        if (m_pos == FRAME_CLKS - 1) m_busy = 1'b0;
        else m_pos++;
      end else if (m_cmd != m_sent || m_force || m_hb == HB - 1) begin
        m_sent = m_cmd; m_force = 1'b0; m_hb = 0; m_busy = 1'b1; m_pos = 0;
        m_bits[0] = 0;
        for (int i = 0; i < 8; i++) m_bits[1 + i] = int'(m_cmd[i]);
`ifdef CMD_PARITY_EN
        m_bits[9] = int'(^m_cmd);
`endif
        m_bits[NBITS - 1] = 1;
      end else if (m_hb < HB - 1) begin
        m_hb++;
      end
      m_cmd = nxt;
    end
  endtask

  // Monitor state: frame statistics and a mid-bit sampling UART receiver.
  bit armed = 1'b0;
  bit busy_prev = 1'b0;
  int n_fd = 0, n_starts = 0, cur_start = 0, last_len = 0, last_end = 0, last_gap = 0;
  bit rx_act = 1'b0;
  int rx_t = 0;
  logic [7:0] rx_byte;
  logic rx_par;
  logic [7:0] rx_q [$];

  initial begin
    forever begin
      @(negedge clk);
      cyc++;
      model_step();
      if (m_in_rst) armed = 1'b1;
      if (armed) begin
        check("tx", tx, m_busy ? m_bits[m_pos / CPB] : 1);
        check("busy", busy, m_busy);
        check("frame_done", frame_done, m_busy && m_pos == FRAME_CLKS - 1);
        check("sent_byte", sent_byte, m_sent);
        if (busy && !busy_prev) begin
          last_gap = cyc - last_end - 1; cur_start = cyc; n_starts++;
        end
        if (!busy && busy_prev) begin
          last_len = cyc - cur_start; last_end = cyc - 1;
        end
        if (frame_done) n_fd++;
        busy_prev = busy;
        if (m_in_rst) begin
          rx_act = 1'b0;
        end else if (!rx_act) begin
          if (tx === 1'b0) begin rx_act = 1'b1; rx_t = 0; rx_byte = 8'h00; end
        end else begin
          rx_t++;
          for (int k = 0; k < 8; k++) if (rx_t == (1 + k) * CPB + CPB / 2) rx_byte[k] = tx;
`ifdef CMD_PARITY_EN
          if (rx_t == 9 * CPB + CPB / 2) begin
            rx_par = tx;
            check("rx_parity", tx, ^rx_byte);
          end
`endif
          if (rx_t == (NBITS - 1) * CPB + CPB / 2) begin
            check("rx_stop", tx, 1);
            rx_q.push_back(rx_byte);
            rx_act = 1'b0;
          end
        end
      end
    end
  end

  task automatic tick();
    @(negedge clk);
    #2;
  endtask

  task automatic wait_fd(input int target, input int limit, input string nm);
    int t;
    t = 0;
    while (n_fd < target && t < limit) begin tick(); t++; end
    if (n_fd < target) check({"timeout_", nm}, n_fd, target);
    tick();
  endtask

  task automatic wait_tx_low(output int lat, input int limit);
    lat = 0;
    while (tx !== 1'b0 && lat < limit) begin tick(); lat++; end
  endtask

  function automatic logic [7:0] last_rx();
    if (rx_q.size() == 0) return 8'hxx;
    return rx_q[$];
  endfunction

  task automatic set_flags(input logic [8:0] f);
    {stop, wa, wd, as, ds, w, s, a, d} = f;
  endtask

  initial begin
    int lat, fd_base, starts_snap, r;
    logic [8:0] f;
    rst = 1'b1; auto_on = 1'b0; set_flags(9'h000);
    repeat (5) tick();
    check("reset_tx", tx, 1);
    check("reset_busy", busy, 0);
    check("reset_sent", sent_byte, 8'h00);

    // Forced frame after reset release.
    rst = 1'b0;
    wait_fd(1, 300, "first_frame");
    check("first_len", last_len, FRAME_CLKS);
    check("first_rx", last_rx(), 8'h00);
    check("first_fd_count", n_fd, 1);
    check("first_starts", n_starts, 1);

    // Auto mode with forward-left: 0x85, LSB first 1,0,1,0,0,0,0,1.
    repeat (5) tick();
    auto_on = 1'b1; wa = 1'b1;
    wait_tx_low(lat, 20);
    check("change_latency", lat, 2);
    fd_base = n_fd;
    wait_fd(fd_base + 1, 300, "wa_frame");
    check("wa_rx", last_rx(), 8'h85);
    check("wa_sent", sent_byte, 8'h85);
`ifdef CMD_PARITY_EN
    check("wa_parity", rx_par, 1'b1);
    check("wa_len", last_len, 110);
`else
    check("wa_len", last_len, 100);
`endif

    // stop wins over w, then w alone.
    auto_on = 1'b0; wa = 1'b0; w = 1'b1; stop = 1'b1;
    fd_base = n_fd;
    wait_fd(fd_base + 1, 300, "stop_frame");
    check("stop_rx", last_rx(), 8'h00);
    stop = 1'b0;
    fd_base = n_fd;
    repeat (20) tick();
    w = 1'b0; d = 1'b1;
    repeat (20) tick();
    s = 1'b1;
    wait_fd(fd_base + 1, 300, "w_frame");
    check("w_rx", last_rx(), 8'h01);
    wait_fd(fd_base + 2, 300, "s_frame");
    check("s_rx", last_rx(), 8'h02);
    check("s_gap", last_gap, 1);
    starts_snap = n_starts;
    repeat (30) tick();
    check("no_extra_frame", n_starts, starts_snap);

    // Heartbeat resends after 50 idle cycles, twice.
    wait_fd(fd_base + 3, 300, "hb1");
    check("hb1_rx", last_rx(), 8'h02);
    check("hb1_gap", last_gap, 50);
    wait_fd(fd_base + 4, 300, "hb2");
    check("hb2_gap", last_gap, 50);

    // Reset during bit 4 aborts; forced 0x00 frame, then the pending 0x85.
    s = 1'b0; d = 1'b0; auto_on = 1'b1; wa = 1'b1;
    wait_tx_low(lat, 100);
    repeat (4 * CPB + 3) tick();
    rst = 1'b1;
    tick();
    check("abort_tx", tx, 1);
    check("abort_busy", busy, 0);
    check("abort_sent", sent_byte, 8'h00);
    rst = 1'b0;
    fd_base = n_fd;
    wait_fd(fd_base + 1, 300, "post_abort");
    check("post_abort_rx", last_rx(), 8'h00);
    wait_fd(fd_base + 2, 300, "post_abort_85");
    check("post_abort_85_rx", last_rx(), 8'h85);
    check("post_abort_len", last_len, FRAME_CLKS);

    // Randomized traffic against the model.
    for (int i = 0; i < 4000; i++) begin
      r = $urandom_range(0, 99);
      if (r < 5) begin
        auto_on = 1'($urandom);
        set_flags(9'($urandom));
      end else if (r < 9) begin
        f = 9'h001 << $urandom_range(0, 8);
        set_flags(f);
      end else if (r == 9) begin
        set_flags(9'h000);
      end
      rst = ($urandom_range(0, 499) == 0);
      tick();
    end
    rst = 1'b0;
    repeat (3) tick();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "watchdog");
  end

endmodule
